run_detector: RTL and testbench
===============================

# run_detector

Parametrised run-length detector for a serial bit stream. Each qualified sample of `w` extends or restarts the current run of equal bits. The block flags runs of at least `RUN_LEN` identical bits, with per-polarity enable, a saturating run counter, a one-shot hit pulse and a detection event counter. It is the general replacement for the fixed four-zeros/four-ones detector and sits between the switch/key input conditioning and the LED/status logic.

## Interface
- `RUN_LEN`, 4, run length that asserts detection; legal range 2 to 2^CNT_W−1.
- `CNT_W`, 4, width of the run-length counter.
- `EVT_W`, 8, width of the detection event counter.

- `Clock`  in  1  rising-edge clock for all state.
- `Reset`  in  1  asynchronous, active-high; forces the reset state immediately.
- `en`  in  1  sample qualifier; `w` is consumed only on edges where `en`=1.
- `w`  in  1  serial data bit.
- `mode`  in  2  detection enable: 00 = both polarities, 01 = zeros only, 10 = ones only, 11 = detection disabled.
- `clr_evt`  in  1  synchronous clear of `evt_cnt`.
- `z`  out  1  run of ≥ `RUN_LEN` of an enabled polarity is in progress.
- `z_val`  out  1  bit value of the current run.
- `run_len`  out  CNT_W  length of the current run, saturating.
- `hit`  out  1  one-cycle pulse on the sample that completes a qualifying run.
- `evt_cnt`  out  EVT_W  count of `hit` pulses, wrapping.

## Operation
- State machine with three states:
  - IDLE: no sample taken since reset.
  - RUN0: current run is zeros.
  - RUN1: current run is ones.
- Reset values:
  - State IDLE.
  - `run_len`=0, `z_val`=0, `hit`=0, `evt_cnt`=0.
  - `z`=0.
- On an edge with `en`=1:
  - From IDLE: go to RUN0 or RUN1 per `w`; `run_len`=1; `z_val`=`w`.
  - `w` equals the current run value: stay in the state; `run_len` increments and saturates at 2^CNT_W−1 (no wrap).
  - `w` differs from the current run value: switch to the other RUN state; `run_len`=1; `z_val`=`w`.
- On an edge with `en`=0: all state holds, and `hit` returns to 0.
- `hit`:
  - Registered. It is 1 for exactly the cycle after an edge where `run_len` steps from `RUN_LEN`−1 to `RUN_LEN`, and only if `mode` enables `w`'s polarity at that edge.
  - It does not re-fire while the run continues or while `run_len` is saturated.
- `z`:
  - Combinational from registered state and the live `mode`: `z` = (`run_len` ≥ `RUN_LEN`) AND `mode` enables `z_val`.
  - A `mode` change affects `z` in the same cycle; `hit` is never produced retroactively.
- `evt_cnt`:
  - Increments by 1, wrapping modulo 2^EVT_W, on each edge that sets `hit`.
  - `clr_evt`=1 clears it to 0.
  - If `clr_evt` and a hit-producing sample occur on the same edge, `evt_cnt` becomes 1.
- `mode`=11: run tracking continues normally; `z`, `hit` and `evt_cnt` increments are suppressed.

## Timing
- Sample-to-output latency:
  - `run_len`, `z_val`, `hit`, `evt_cnt` are valid one clock after the qualifying edge.
  - `z` is valid in the same cycle as `run_len`.
- Reset asserted mid-run:
  - All outputs drop to their reset values immediately, without waiting for a clock edge.
  - The first sample after `Reset` deasserts starts a new run with `run_len`=1.
- Back-to-back samples (`en` held at 1) are supported at full clock rate.
- A polarity change on the sample that would have been the `RUN_LEN`-th produces no `hit`.

## Test plan
- Zeros run: defaults, `mode`=00, `w`=0 for 4 samples.
  - `run_len` goes 1,2,3,4.
  - `z` rises after sample 4; `hit` pulses once; `evt_cnt`=1.
  - A fifth 0 gives `run_len`=5, `z`=1, no `hit`.
- Polarity switch: stream 1,1,1,0,1,1,1,1.
  - `run_len` resets to 1 at the 0 and again at the following 1.
  - `z`=1, `z_val`=1 and `hit` occur only after the final sample; `evt_cnt`=1.
- Gated samples: `en` low between samples, stream 0,0,0,0 with 3 idle cycles between each.
  - Same results as the zeros-run scenario.
  - `hit` is high for exactly one cycle.
- Mode filter and saturation:
  - `mode`=10 with six 0s: `z`=0, no `hit`; switching `mode` to 00 raises `z` the same cycle.
  - 20 consecutive 1s: `run_len` saturates at 15 and a single `hit` is produced.
- Reset and clear:
  - `Reset` asserted mid-clock at `run_len`=3: outputs clear asynchronously.
  - `evt_cnt` at 255 plus a hit: wraps to 0.
  - `clr_evt` coincident with a hit: `evt_cnt`=1.

Source files
------------

// File: rtl/run_detector_if.sv
// Sample/control and status bundle for run_detector.
// The bench (or upstream conditioning logic) is the master; the detector is the slave.
interface run_detector_if #(
    parameter int CNT_W = 4,
    parameter int EVT_W = 8
);
    logic             en;
    logic             w;
    logic [1:0]       mode;
    logic             clr_evt;
    logic             z;
    logic             z_val;
    logic [CNT_W-1:0] run_len;
    logic             hit;
    logic [EVT_W-1:0] evt_cnt;

    modport master (
        output en, w, mode, clr_evt,
        input  z, z_val, run_len, hit, evt_cnt
    );

    modport slave (
        input  en, w, mode, clr_evt,
        output z, z_val, run_len, hit, evt_cnt
    );
endinterface

// File: rtl/run_detector.sv
// Run-length detector for a qualified serial bit stream: tracks the current run of equal
// bits, flags runs of at least RUN_LEN of an enabled polarity and counts detections.
module run_detector #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 4,
    parameter int EVT_W   = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    run_detector_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN0 = 2'd1,
        RUN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] RUN_PRE_C = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] RUN_MAX_C = '1;
    localparam logic [CNT_W-1:0] RUN_ONE_C = CNT_W'(1);
    localparam logic [EVT_W-1:0] EVT_ONE_C = EVT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic             z_val_q, z_val_d;
    logic             hit_q, hit_d;
    logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;

    // mode: 00 both, 01 zeros only, 10 ones only, 11 none
    function automatic logic pol_enabled(input logic [1:0] mode, input logic bit_val);
        unique case (mode)
            2'b00:   pol_enabled = 1'b1;
            2'b01:   pol_enabled = ~bit_val;
            2'b10:   pol_enabled = bit_val;
            default: pol_enabled = 1'b0;
        endcase
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            run_len_q <= '0;
            z_val_q   <= 1'b0;
            hit_q     <= 1'b0;
            evt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            z_val_q   <= z_val_d;
            hit_q     <= hit_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        z_val_d   = z_val_q;
        hit_d     = 1'b0;
        evt_cnt_d = evt_cnt_q;

        if (bus.en) begin
            unique case (state_q)
                RUN0, RUN1: begin
                    if (bus.w == (state_q == RUN1)) begin
                        if (run_len_q != RUN_MAX_C) begin
                            run_len_d = run_len_q + RUN_ONE_C;
                        end
                        // Only the step into RUN_LEN fires, so saturation never re-triggers.
                        hit_d = (run_len_q == RUN_PRE_C) && pol_enabled(bus.mode, bus.w);
                    end else begin
                        state_d   = bus.w ? RUN1 : RUN0;
                        run_len_d = RUN_ONE_C;
                        z_val_d   = bus.w;
                    end
                end
                default: begin
                    state_d   = bus.w ? RUN1 : RUN0;
                    run_len_d = RUN_ONE_C;
                    z_val_d   = bus.w;
                end
            endcase
        end

        // A clear coincident with a new detection leaves that detection counted.
        if (bus.clr_evt) begin
            evt_cnt_d = hit_d ? EVT_ONE_C : '0;
        end else if (hit_d) begin
            evt_cnt_d = evt_cnt_q + EVT_ONE_C;
        end
    end

    assign bus.z       = (run_len_q >= RUN_LEN_C) && pol_enabled(bus.mode, z_val_q);
    assign bus.z_val   = z_val_q;
    assign bus.run_len = run_len_q;
    assign bus.hit     = hit_q;
    assign bus.evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_run_detector.sv
// Self-checking bench for run_detector: directed vector table, hand-written corner
// sequences and a randomized stream against a history-based reference model.
module tb_run_detector;

    localparam int RUN_LEN = 4;
    localparam int CNT_W   = 4;
    localparam int EVT_W   = 8;
    localparam int RUN_MAX = (1 << CNT_W) - 1;
    localparam int EVT_MOD = 1 << EVT_W;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    run_detector_if #(.CNT_W(CNT_W), .EVT_W(EVT_W)) bus ();

    run_detector #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the full history of accepted bits; run length is the count of
    // trailing equal bits, detection happens when that count reaches RUN_LEN exactly.
    bit hist[$];
    int evt_m;
    bit hit_m;

    function automatic bit mode_ok(input logic [1:0] m, input bit b);
        if (m == 2'b00) return 1'b1;
        if (m == 2'b01) return !b;
        if (m == 2'b10) return b;
        return 1'b0;
    endfunction

    function automatic int trailing();
        int n = 0;
        if (hist.size() == 0) return 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == hist[hist.size() - 1]) n++;
            else break;
        end
        return n;
    endfunction

    function automatic void model_reset();
        hist.delete();
        evt_m = 0;
        hit_m = 1'b0;
    endfunction

    function automatic void model_edge(input bit e, input bit b, input logic [1:0] m, input bit c);
        hit_m = 1'b0;
        if (e) begin
            hist.push_back(b);
            if (hist.size() > 40) void'(hist.pop_front());
            hit_m = (trailing() == RUN_LEN) && mode_ok(m, b);
        end
        if (c) evt_m = hit_m ? 1 : 0;
        else if (hit_m) evt_m = (evt_m + 1) % EVT_MOD;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int  cnt;
        int  rl;
        bit  zv;
        cnt = trailing();
        rl  = (cnt > RUN_MAX) ? RUN_MAX : cnt;
        zv  = (hist.size() != 0) ? hist[hist.size() - 1] : 1'b0;
        chk({tag, " run_len"}, 32'(bus.run_len), 32'(rl));
        chk({tag, " z_val"},   32'(bus.z_val),   32'(zv));
        chk({tag, " z"},       32'(bus.z),       32'((rl >= RUN_LEN) && mode_ok(bus.mode, zv)));
        chk({tag, " hit"},     32'(bus.hit),     32'(hit_m));
        chk({tag, " evt_cnt"}, 32'(bus.evt_cnt), 32'(evt_m));
    endtask

    task automatic step(input bit e, input bit b, input logic [1:0] m, input bit c);
        bus.en      = e;
        bus.w       = b;
        bus.mode    = m;
        bus.clr_evt = c;
        model_edge(e, b, m, c);
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        bus.en      = 1'b0;
        bus.clr_evt = 1'b0;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit         do_rst;
        bit         en;
        bit         w;
        logic [1:0] mode;
        bit         clr;
        int         exp_run;
        bit         exp_z;
        bit         exp_zval;
        bit         exp_hit;
        int         exp_evt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int hits;
        int e_cnt;

        bus.en = 1'b0; bus.w = 1'b0; bus.mode = 2'b00; bus.clr_evt = 1'b0;
        model_reset();

        // Reset state
        #2;
        chk("reset run_len", 32'(bus.run_len), 0);
        chk("reset z",       32'(bus.z),       0);
        chk("reset z_val",   32'(bus.z_val),   0);
        chk("reset hit",     32'(bus.hit),     0);
        chk("reset evt_cnt", 32'(bus.evt_cnt), 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // Zeros run, one idle cycle, then the polarity-switch stream from a fresh reset
        //           rst en w  mode  clr run z  zv hit evt
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1, 1'b0, 1'b1, 1'b0, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2, 1'b0, 1'b1, 1'b0, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 3, 1'b0, 1'b1, 1'b0, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1, 1'b0, 1'b0, 1'b0, 0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1, 1'b0, 1'b1, 1'b0, 0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2, 1'b0, 1'b1, 1'b0, 0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 3, 1'b0, 1'b1, 1'b0, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4, 1'b1, 1'b1, 1'b1, 1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1};

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) do_reset();
            step(tbl[i].en, tbl[i].w, tbl[i].mode, tbl[i].clr);
            chk($sformatf("tbl[%0d] run_len", i), 32'(bus.run_len), 32'(tbl[i].exp_run));
            chk($sformatf("tbl[%0d] z", i),       32'(bus.z),       32'(tbl[i].exp_z));
            chk($sformatf("tbl[%0d] z_val", i),   32'(bus.z_val),   32'(tbl[i].exp_zval));
            chk($sformatf("tbl[%0d] hit", i),     32'(bus.hit),     32'(tbl[i].exp_hit));
            chk($sformatf("tbl[%0d] evt_cnt", i), 32'(bus.evt_cnt), 32'(tbl[i].exp_evt));
        end

        // Gated samples: four zeros with three idle cycles between them
        do_reset();
        hits = 0;
        for (int s = 0; s < 4; s++) begin
            step(1'b1, 1'b0, 2'b00, 1'b0);
            check_model($sformatf("gated s%0d", s));
            if (bus.hit) hits++;
            for (int k = 0; k < 3; k++) begin
                step(1'b0, 1'b1, 2'b00, 1'b0);
                check_model($sformatf("gated s%0d idle%0d", s, k));
                if (bus.hit) hits++;
            end
        end
        chk("gated hit cycles", 32'(hits), 1);
        chk("gated run_len", 32'(bus.run_len), 4);
        chk("gated evt_cnt", 32'(bus.evt_cnt), 1);

        // Mode filter: ones-only sees no detection on zeros; switching to both raises z at once
        do_reset();
        hits = 0;
        for (int s = 0; s < 6; s++) begin
            step(1'b1, 1'b0, 2'b10, 1'b0);
            if (bus.hit) hits++;
        end
        chk("modefilt z", 32'(bus.z), 0);
        chk("modefilt hits", 32'(hits), 0);
        chk("modefilt evt_cnt", 32'(bus.evt_cnt), 0);
        bus.mode = 2'b00;
        #1;
        chk("modefilt z after mode 00", 32'(bus.z), 1);
        chk("modefilt no retro hit", 32'(bus.hit), 0);
        bus.mode = 2'b11;
        #1;
        chk("mode 11 z", 32'(bus.z), 0);

        // Saturation: 20 ones produce one hit and stop at the counter maximum
        do_reset();
        hits = 0;
        for (int s = 0; s < 20; s++) begin
            step(1'b1, 1'b1, 2'b00, 1'b0);
            check_model($sformatf("sat s%0d", s));
            if (bus.hit) hits++;
        end
        chk("sat run_len", 32'(bus.run_len), 15);
        chk("sat hits", 32'(hits), 1);

        // Asynchronous reset mid-run
        do_reset();
        for (int s = 0; s < 3; s++) step(1'b1, 1'b0, 2'b00, 1'b0);
        chk("pre-reset run_len", 32'(bus.run_len), 3);
        #2;
        Reset = 1'b1;
        #1;
        chk("async rst run_len", 32'(bus.run_len), 0);
        chk("async rst z_val",   32'(bus.z_val),   0);
        chk("async rst z",       32'(bus.z),       0);
        chk("async rst evt_cnt", 32'(bus.evt_cnt), 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_reset();
        step(1'b1, 1'b1, 2'b00, 1'b0);
        chk("post-reset run_len", 32'(bus.run_len), 1);
        chk("post-reset z_val", 32'(bus.z_val), 1);

        // Event counter wrap: 255 hits, then one more
        do_reset();
        for (int h = 0; h < 255; h++)
            for (int s = 0; s < RUN_LEN; s++) step(1'b1, 1'(h % 2), 2'b00, 1'b0);
        chk("evt at 255", 32'(bus.evt_cnt), 255);
        for (int s = 0; s < RUN_LEN; s++) step(1'b1, 1'b1, 2'b00, 1'b0);
        chk("evt wrap hit", 32'(bus.hit), 1);
        chk("evt wrap", 32'(bus.evt_cnt), 0);

        // Clear coincident with a hit leaves the count at one
        do_reset();
        for (int s = 0; s < RUN_LEN; s++) step(1'b1, 1'b1, 2'b00, 1'b0);
        chk("clr pre evt", 32'(bus.evt_cnt), 1);
        for (int s = 0; s < RUN_LEN - 1; s++) step(1'b1, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b1);
        chk("clr+hit hit", 32'(bus.hit), 1);
        chk("clr+hit evt", 32'(bus.evt_cnt), 1);
        step(1'b0, 1'b0, 2'b00, 1'b1);
        chk("clr alone evt", 32'(bus.evt_cnt), 0);

        // Randomized stream against the reference model
        do_reset();
        begin
            bit         b = 1'b0;
            logic [1:0] m = 2'b00;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(4, 0) == 0) b = ~b;
                if ($urandom_range(39, 0) == 0) m = 2'($urandom_range(3, 0));
                step(($urandom_range(3, 0) != 0), b, m, ($urandom_range(63, 0) == 0));
                check_model($sformatf("rand %0d", n));
            end
        end
        e_cnt = evt_m;
        chk("rand final evt", 32'(bus.evt_cnt), 32'(e_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
